// File: rtl/mesi_bus_arbiter_if.sv
// mesi_bus_arbiter_if: core request, snoop-reply and memory signals of the shared coherence bus
interface mesi_bus_arbiter_if #(
    parameter int NUM_CORES        = 2,
    parameter int CACHE_BLOCK_SIZE = 8,
    parameter int BUS_W            = 2 + 3 + 2 + 2 + CACHE_BLOCK_SIZE
);
    logic [NUM_CORES-1:0]                  req_valid;
    logic [NUM_CORES*BUS_W-1:0]            req_pkt;
    logic [NUM_CORES-1:0]                  grant;
    logic [BUS_W-1:0]                      bus_out;
    logic                                  bus_valid;
    logic [NUM_CORES-1:0]                  snp_done;
    logic [NUM_CORES-1:0]                  snp_shared;
    logic [NUM_CORES-1:0]                  snp_supply;
    logic [NUM_CORES*CACHE_BLOCK_SIZE-1:0] snp_data;
    logic                                  mem_rd_req;
    logic                                  mem_wr_req;
    logic [3:0]                            mem_addr;
    logic [CACHE_BLOCK_SIZE-1:0]           mem_wr_data;
    logic [CACHE_BLOCK_SIZE-1:0]           mem_rd_data;
    logic                                  mem_rd_ack;
    logic                                  mem_wr_ack;
    logic                                  resp_valid;
    logic [CACHE_BLOCK_SIZE-1:0]           resp_data;
    logic                                  resp_shared;
    logic                                  snp_timeout;
    modport master (
        input  req_valid, req_pkt, snp_done, snp_shared, snp_supply, snp_data,
               mem_rd_data, mem_rd_ack, mem_wr_ack,
        output grant, bus_out, bus_valid, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
               resp_valid, resp_data, resp_shared, snp_timeout
    );
    modport slave (
        output req_valid, req_pkt, snp_done, snp_shared, snp_supply, snp_data,
               mem_rd_data, mem_rd_ack, mem_wr_ack,
        input  grant, bus_out, bus_valid, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
               resp_valid, resp_data, resp_shared, snp_timeout
    );
endinterface

// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter: round-robin snooping-bus controller; broadcasts one transaction,
// gathers snoop replies and completes it from a supplying cache or memory.
module mesi_bus_arbiter #(
    parameter int NUM_CORES        = 2,
    parameter int CACHE_BLOCK_SIZE = 8,
    parameter int SNOOP_TIMEOUT    = 15
) (
    input logic                clk,
    input logic                resetn,
    mesi_bus_arbiter_if.master bus
);
    localparam int CB    = CACHE_BLOCK_SIZE;
    localparam int BUS_W = 9 + CB;
    localparam int CW    = $clog2(SNOOP_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GRANT, SNOOP, WB, MEM_RD, MEM_WR, RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           rr_q, rr_d, own_q, own_d, sup_idx_q, sup_idx_d, win;
    logic [BUS_W-1:0]     pkt_q, pkt_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_CORES-1:0] done_q, done_d, shr_q, shr_d, sup_q, sup_d;
    logic [NUM_CORES-1:0] own_vec, done_now, sup_now;
    logic [CB-1:0]        data_q, data_d;
    logic [2:0]           txn;
    logic                 is_rd, is_rdx, is_fl, all_done, expired;

    assign own_vec  = {{(NUM_CORES-1){1'b0}}, 1'b1} << own_q;
    assign txn      = pkt_q[CB+6:CB+4];
    assign is_rd    = txn == 3'b001;
    assign is_rdx   = txn == 3'b010;
    assign is_fl    = txn == 3'b100;
    // The requester's own snoop reply lines are masked out everywhere.
    assign done_now = done_q | (bus.snp_done & ~own_vec);
    assign sup_now  = sup_q | (bus.snp_supply & ~own_vec);
    assign all_done = &(done_now | own_vec);
    assign expired  = cnt_q == CW'(SNOOP_TIMEOUT);

    // Lowest requester at or after rr_q wins; otherwise wrap to the lowest overall.
    always_comb begin
        win = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (bus.req_valid[i]) win = 2'(i);
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (bus.req_valid[i] && i >= int'(rr_q)) win = 2'(i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            own_q     <= '0;
            sup_idx_q <= '0;
            pkt_q     <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
            shr_q     <= '0;
            sup_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            own_q     <= own_d;
            sup_idx_q <= sup_idx_d;
            pkt_q     <= pkt_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            shr_q     <= shr_d;
            sup_q     <= sup_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        own_d     = own_q;
        sup_idx_d = sup_idx_q;
        pkt_d     = pkt_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        shr_d     = shr_q;
        sup_d     = sup_q;
        data_d    = data_q;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                state_d = GRANT;
                own_d   = win;
                rr_d    = (win == 2'(NUM_CORES - 1)) ? 2'd0 : win + 2'd1;
                pkt_d   = bus.req_pkt[int'(win)*BUS_W +: BUS_W];
                pkt_d[BUS_W-1 -: 2] = win;
            end
            GRANT: begin
                state_d   = SNOOP;
                cnt_d     = '0;
                done_d    = '0;
                shr_d     = '0;
                sup_d     = '0;
                sup_idx_d = '0;
                data_d    = '0;
            end
            SNOOP: begin
                cnt_d  = cnt_q + 1'b1;
                done_d = done_now;
                shr_d  = shr_q | (bus.snp_shared & ~own_vec);
                sup_d  = sup_now;
                for (int i = NUM_CORES - 1; i >= 0; i--)
                    if (bus.snp_supply[i] && !own_vec[i] && (!(|sup_q) || 2'(i) < sup_idx_q)) begin
                        sup_idx_d = 2'(i);
                        data_d    = bus.snp_data[i*CB +: CB];
                    end
                if (all_done || expired)
                    state_d = is_rd  ? (|sup_now ? WB : MEM_RD) :
                              is_rdx ? (|sup_now ? RESP : MEM_RD) :
                              is_fl  ? MEM_WR : RESP;
            end
            WB:     state_d = bus.mem_wr_ack ? RESP : WB;
            MEM_RD: if (bus.mem_rd_ack) begin
                state_d = RESP;
                data_d  = bus.mem_rd_data;
            end
            MEM_WR: state_d = bus.mem_wr_ack ? RESP : MEM_WR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.grant       = (state_q != IDLE) ? own_vec : '0;
        bus.bus_out     = pkt_q;
        bus.bus_valid   = state_q == GRANT;
        bus.mem_rd_req  = state_q == MEM_RD;
        bus.mem_wr_req  = state_q == WB || state_q == MEM_WR;
        bus.mem_addr    = pkt_q[CB+3:CB];
        bus.mem_wr_data = (state_q == WB) ? data_q : (state_q == MEM_WR) ? pkt_q[CB-1:0] : '0;
        bus.resp_valid  = state_q == RESP;
        bus.resp_data   = (state_q == RESP && (is_rd || is_rdx)) ? data_q : '0;
        bus.resp_shared = state_q == RESP && is_rd && |(shr_q | sup_q);
        bus.snp_timeout = state_q == SNOOP && expired && !all_done;
    end
endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// tb_mesi_bus_arbiter: directed transactions against queued bus, response and write-back expectations.
module tb_mesi_bus_arbiter;
    localparam int N = 2, CB = 8, BW = 9 + CB;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [CB-1:0] d;
        logic          s;
    } resp_t;

    logic            clk = 1'b0, resetn = 1'b0, hold = 1'b0;
    logic [N-1:0]    req_v = '0, done_v = '0, shr_v = '0, sup_v = '0;
    logic [N*BW-1:0] pkts = '0;
    logic [N*CB-1:0] sdata = '0;
    logic [CB-1:0]   mem_val = '0;
    int              tests = 0, fails = 0, to_cnt = 0, mem_cyc = 0, lat = 0, l0 = 0, l1 = 0, base = 0;
    resp_t           rq[$];
    logic [BW-1:0]   bq[$];
    logic [11:0]     wq[$];

    mesi_bus_arbiter_if #(.NUM_CORES(N), .CACHE_BLOCK_SIZE(CB)) b();
    mesi_bus_arbiter #(.NUM_CORES(N), .CACHE_BLOCK_SIZE(CB), .SNOOP_TIMEOUT(15)) dut (
        .clk(clk), .resetn(resetn), .bus(b)
    );

    assign b.req_valid   = req_v;
    assign b.req_pkt     = pkts;
    assign b.snp_done    = done_v;
    assign b.snp_shared  = shr_v;
    assign b.snp_supply  = sup_v;
    assign b.snp_data    = sdata;
    assign b.mem_rd_data = mem_val;
    assign b.mem_rd_ack  = b.mem_rd_req & ~hold;
    assign b.mem_wr_ack  = b.mem_wr_req;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({b.grant, b.bus_out, b.bus_valid, b.mem_rd_req, b.mem_wr_req, b.mem_addr,
                    b.mem_wr_data, b.resp_valid, b.resp_data, b.resp_shared, b.snp_timeout});
    endfunction

    task automatic expect_txn(input int c, input logic [2:0] t, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] rd, input logic rs);
        resp_t r;
        r.g = N'(1) << c;
        r.d = rd;
        r.s = rs;
        bq.push_back({2'(c), t, a, d});
        rq.push_back(r);
    endtask

    // pid is sent as 11 on purpose: the arbiter must overwrite it with the granted index
    task automatic run_core(input int c, input logic [2:0] t, input logic [3:0] a,
                            input logic [7:0] d, output int l);
        pkts[c*BW +: BW] = {2'b11, t, a, d};
        req_v[c] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (b.resp_valid && b.grant[c]) begin
                req_v[c] = 1'b0;
                l = n;
                return;
            end
        end
        req_v[c] = 1'b0;
        l = -1;
        tests++;
        fails++;
        $display("FAIL resp_wait core%0d: got none expected resp_valid", c);
    endtask

    always @(negedge clk) if (resetn) begin
        if (b.bus_valid) begin
            if (bq.size() == 0) begin
                tests++; fails++;
                $display("FAIL bus_unexpected: got %0h expected none", b.bus_out);
            end else check("bus_pkt", 64'(b.bus_out), 64'(bq.pop_front()));
        end
        if (b.resp_valid) begin
            if (rq.size() == 0) begin
                tests++; fails++;
                $display("FAIL resp_unexpected: got %0h expected none", b.resp_data);
            end else check("resp", 64'({b.grant, b.resp_data, b.resp_shared}), 64'(rq.pop_front()));
        end
        if (b.mem_wr_req && b.mem_wr_ack) begin
            if (wq.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_unexpected: got %0h expected none", {b.mem_addr, b.mem_wr_data});
            end else check("mem_wr", 64'({b.mem_addr, b.mem_wr_data}), 64'(wq.pop_front()));
        end
        if (b.snp_timeout) to_cnt++;
        if (b.mem_rd_req || b.mem_wr_req) mem_cyc++;
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 64'(0));
        resetn = 1'b1;
        @(negedge clk);
        // BusRd from core0; the requester's own supply/shared lines must be ignored
        done_v = 2'b10; shr_v = 2'b01; sup_v = 2'b01; sdata = {8'h77, 8'h55}; mem_val = 8'hFF;
        expect_txn(0, 3'b001, 4'h0, 8'h00, 8'hFF, 1'b0);
        run_core(0, 3'b001, 4'h0, 8'h00, lat);
        check("rd_latency", 64'(lat), 64'(3));
        @(negedge clk);
        // BusRd from core1 with core0 supplying: write-back then shared response
        done_v = 2'b11; shr_v = 2'b00; sup_v = 2'b01; sdata = {8'h77, 8'd10};
        expect_txn(1, 3'b001, 4'h4, 8'h00, 8'd10, 1'b1);
        wq.push_back({4'h4, 8'd10});
        run_core(1, 3'b001, 4'h4, 8'h00, lat);
        @(negedge clk);
        // Simultaneous BusUpgr from both cores, two rounds
        sup_v = 2'b00;
        repeat (2) begin
            expect_txn(0, 3'b011, 4'h0, 8'h00, 8'h00, 1'b0);
            expect_txn(1, 3'b011, 4'h1, 8'h00, 8'h00, 1'b0);
            fork
                run_core(0, 3'b011, 4'h0, 8'h00, l0);
                run_core(1, 3'b011, 4'h1, 8'h00, l1);
            join
            check("upgr_latency0", 64'(l0), 64'(2));
            check("upgr_latency1", 64'(l1), 64'(6));
            @(negedge clk);
        end
        // Flush writes the packet data to memory and returns no data
        expect_txn(1, 3'b100, 4'h9, 8'h3C, 8'h00, 1'b0);
        wq.push_back({4'h9, 8'h3C});
        run_core(1, 3'b100, 4'h9, 8'h3C, lat);
        @(negedge clk);
        // Undefined code behaves as BusUpgr: no memory, no data, never shared
        shr_v = 2'b10; base = mem_cyc;
        expect_txn(0, 3'b111, 4'h5, 8'h12, 8'h00, 1'b0);
        run_core(0, 3'b111, 4'h5, 8'h12, lat);
        check("odd_txn_mem", 64'(mem_cyc - base), 64'(0));
        @(negedge clk);
        // Snoop timeout: core1 never answers
        done_v = 2'b00; shr_v = 2'b00;
        check("no_early_timeout", 64'(to_cnt), 64'(0));
        expect_txn(0, 3'b011, 4'h2, 8'h00, 8'h00, 1'b0);
        run_core(0, 3'b011, 4'h2, 8'h00, lat);
        check("timeout_latency", 64'(lat), 64'(17));
        check("timeout_pulses", 64'(to_cnt), 64'(1));
        @(negedge clk);
        // BusRdX served by core1 with no memory traffic
        done_v = 2'b10; sup_v = 2'b10; sdata = {8'd30, 8'hAA}; base = mem_cyc;
        expect_txn(0, 3'b010, 4'h3, 8'h00, 8'd30, 1'b0);
        run_core(0, 3'b010, 4'h3, 8'h00, lat);
        check("rdx_latency", 64'(lat), 64'(2));
        check("rdx_mem", 64'(mem_cyc - base), 64'(0));
        @(negedge clk);
        // Reset while stalled in MEM_RD
        sup_v = 2'b00; hold = 1'b1;
        bq.push_back({2'd0, 3'b001, 4'h2, 8'h00});
        pkts[BW-1:0] = {2'b11, 3'b001, 4'h2, 8'h00};
        req_v[0] = 1'b1;
        for (int n = 0; n < 20 && !b.mem_rd_req; n++) @(negedge clk);
        check("stall_mem_rd", 64'(b.mem_rd_req), 64'(1));
        check("stall_grant", 64'(b.grant), 64'(1));
        #2 resetn = 1'b0;
        #1 check("async_reset_outs", outs(), 64'(0));
        req_v = '0; hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        // rr pointer restarts from core0
        done_v = 2'b11;
        expect_txn(0, 3'b011, 4'h6, 8'h00, 8'h00, 1'b0);
        expect_txn(1, 3'b011, 4'h7, 8'h00, 8'h00, 1'b0);
        fork
            run_core(0, 3'b011, 4'h6, 8'h00, l0);
            run_core(1, 3'b011, 4'h7, 8'h00, l1);
        join
        check("post_reset_first", 64'(l0), 64'(2));
        @(negedge clk);
        check("queues_empty", 64'(rq.size() + bq.size() + wq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mesi_bus_arbiter.md
# mesi_bus_arbiter

Shared snooping-bus controller for the MESI cache cores. It replaces point-to-point core-to-core buses with one arbitrated coherence bus. It grants the bus round-robin to one requesting core, broadcasts the transaction, and collects snoop replies from every other core. It then completes the transaction from a supplying cache or from memory, writing back dirty data where the protocol needs it.

## Interface
Parameters:
- NUM_CORES, 2, number of cores on the bus (2..4); pid field is 2 bits
- CACHE_BLOCK_SIZE, 8, block width in bits
- SNOOP_TIMEOUT, 15, maximum cycles spent in SNOOP before forced completion
- BUS_W (derived), 2+3+2+2+CACHE_BLOCK_SIZE, packet width {pid[2], txn[3], tag[2], index[2], data}

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_CORES  core i requests the bus; held until its resp_valid
- req_pkt  in  NUM_CORES*BUS_W  packed packets, core i at [i*BUS_W +: BUS_W]
- grant  out  NUM_CORES  one-hot owner of the current transaction
- bus_out  out  BUS_W  broadcast packet; pid field forced to granted index
- bus_valid  out  1  one-cycle broadcast strobe
- snp_done  in  NUM_CORES  snooper i finished its lookup
- snp_shared  in  NUM_CORES  snooper i holds a valid copy
- snp_supply  in  NUM_CORES  snooper i drives data (was M)
- snp_data  in  NUM_CORES*CACHE_BLOCK_SIZE  supplied block, core i slice
- mem_rd_req / mem_wr_req  out  1  memory read / write request, held until ack
- mem_addr  out  4  {tag,index} of the latched packet
- mem_wr_data  out  CACHE_BLOCK_SIZE  write-back / flush data
- mem_rd_data  in  CACHE_BLOCK_SIZE; mem_rd_ack, mem_wr_ack  in  1
- resp_valid  out  1  one-cycle completion to the granted core
- resp_data  out  CACHE_BLOCK_SIZE  block for BusRd/BusRdX
- resp_shared  out  1  requester installs S (1) or E (0)
- snp_timeout  out  1  one-cycle pulse when SNOOP expired

## Operation
- Txn codes: 001 BusRd, 010 BusRdX, 011 BusUpgr, 100 Flush. All other codes complete as BusUpgr (no data, no memory access).
- States: IDLE, GRANT, SNOOP, WB, MEM_RD, MEM_WR, RESP.
- IDLE: if any req_valid, pick the first set bit at or after rr_ptr (wrapping), latch its packet and index → GRANT. rr_ptr ← winner+1 mod NUM_CORES. rr_ptr resets to 0.
- GRANT: bus_valid=1, bus_out = latched packet → SNOOP; timeout counter cleared.
- SNOOP: sticky-accumulate snp_done/shared/supply from non-requesters (requester bits ignored). Capture supplier data; the lowest supplying index wins. Exit when all non-requesters are done, or when counter reaches SNOOP_TIMEOUT (pulse snp_timeout; missing cores count as not shared/not supplying).
- SNOOP exit: BusRd+supply → WB; BusRd no supply → MEM_RD; BusRdX+supply → RESP; BusRdX no supply → MEM_RD; BusUpgr → RESP; Flush → MEM_WR (data = packet data field).
- WB: mem_wr_req with supplied data until mem_wr_ack → RESP. MEM_RD: mem_rd_req until mem_rd_ack, capture mem_rd_data → RESP. MEM_WR: until mem_wr_ack → RESP.
- RESP: resp_valid=1; resp_data = supplied or memory data (0 for Upgr/Flush). resp_shared = OR(shared|supply) for BusRd only. → IDLE, grant cleared.
- grant is held from GRANT through RESP inclusive. Requester dropping req_valid mid-transaction is ignored. A request from the same core is re-arbitrated in IDLE only.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0; grant, bus_out, bus_valid, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, resp_valid, resp_data, resp_shared, snp_timeout all 0. Reset mid-transaction aborts with no response.
- req sampled at edge 0 → GRANT in cycle 1 → SNOOP in cycle 2 (zero-wait snoop exits at end of cycle 2).
- BusUpgr minimum latency: resp_valid in cycle 3. BusRd with same-cycle mem ack: MEM_RD cycle 3, resp_valid cycle 4.
- Memory requests assert on state entry and drop the cycle after ack. Ack in the entry cycle is legal.
- Timeout: SNOOP lasts at most SNOOP_TIMEOUT+1 cycles.
- Simultaneous requests from all cores with rr_ptr=0: serviced 0,1,..,N-1; no core is granted twice while another waits.

## Test plan
- Single BusRd from core0 to 0x0, core1 done/not shared, mem returns 8'hFF → resp_data FF, resp_shared 0, resp_valid cycle 4.
- Core1 BusRd to 0x4 while core0 supplies 8'd10 → WB writes 10 to addr 4, resp_data 10, resp_shared 1.
- Both cores request in the same cycle after reset → core0 granted first, core1 next; third round starts from core0 again.
- Core0 BusUpgr, core1 snp_done never asserted → snp_timeout pulse after 16 SNOOP cycles, resp_valid follows, resp_shared 0.
- Core0 BusRdX, core1 supplies 8'd30 → no memory access, resp_data 30.
- resetn low while in MEM_RD → all outputs 0 immediately; next request is arbitrated from core0.
